// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// StallCnt/FlushCnt and the CNT_W parameter exist only when HAZARD_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int unsigned CNT_W = 32)
`endif
  ;
  logic [4:0] Rs1D, Rs2D;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic       MultiCycleE;
  logic [4:0] RdM, RdW;
  logic       RegWriteM, RegWriteW;

  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD;
  logic       FlushD, FlushE;
  logic       EnE;
  logic       BubbleM;
  logic       BusyE;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] StallCnt, FlushCnt;
`endif

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, MultiCycleE,
           RdM, RdW, RegWriteM, RegWriteW,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, EnE, BubbleM, BusyE
`ifdef HAZARD_PERF_CNT_EN
    , input StallCnt, FlushCnt
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, MultiCycleE,
           RdM, RdW, RegWriteM, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, EnE, BubbleM, BusyE
`ifdef HAZARD_PERF_CNT_EN
    , output StallCnt, FlushCnt
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: ALU forwarding selects, load-use and branch flushes, and a
// countdown FSM holding Execute for multi-cycle ops. HAZARD_PERF_CNT_EN adds saturating counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic {IDLE, BUSY} state_t;

  if (MC_LAT < 2 || MC_LAT > 255 || CNT_W < 1) begin : g_param_check
    $error("pipe_hazard_ctrl: MC_LAT must be 2..255 and CNT_W at least 1");
  end

  state_t     state;
  logic [7:0] cnt;
  logic       busy;
  logic       mc_stall;
  logic       lw_stall;
  logic       stall;
  logic       flush_e;
  logic       flush_d;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // Memory-stage result wins over Writeback; x0 is hardwired and never forwarded.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hz.RegWriteM && hz.RdM == hz.Rs1E && hz.Rs1E != 5'd0)      fwd_a = 2'b10;
    else if (hz.RegWriteW && hz.RdW == hz.Rs1E && hz.Rs1E != 5'd0) fwd_a = 2'b01;
    if (hz.RegWriteM && hz.RdM == hz.Rs2E && hz.Rs2E != 5'd0)      fwd_b = 2'b10;
    else if (hz.RegWriteW && hz.RdW == hz.Rs2E && hz.Rs2E != 5'd0) fwd_b = 2'b01;
  end

  // A held Execute register must not be flushed, so mc_stall masks both flushes.
  always_comb begin
    lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
               (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    mc_stall = (state == IDLE) ? hz.MultiCycleE : (cnt != 8'd0);
    stall    = ~reset & (lw_stall | mc_stall);
    flush_e  = ~reset & (lw_stall | hz.PCSrcE) & ~mc_stall;
    flush_d  = ~reset & hz.PCSrcE & ~mc_stall;
  end

  // cnt == 0 in BUSY is the release cycle; MultiCycleE is ignored there.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hz.MultiCycleE) begin
            state <= BUSY;
            cnt   <= 8'(MC_LAT - 2);
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hz.ForwardAE = reset ? 2'b00 : fwd_a;
  assign hz.ForwardBE = reset ? 2'b00 : fwd_b;
  assign hz.StallF    = stall;
  assign hz.StallD    = stall;
  assign hz.FlushE    = flush_e;
  assign hz.FlushD    = flush_d;
  assign hz.EnE       = reset | ~mc_stall;
  assign hz.BubbleM   = ~reset & mc_stall;
  assign hz.BusyE     = busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((flush_e || flush_d) && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.StallCnt = stall_cnt;
  assign hz.FlushCnt = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against an
// occupancy-based reference model (pipeline position of the multi-cycle op).
module tb_pipe_hazard_ctrl;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam logic [10:0] RST_VEC = 11'b0000_0000100;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  // model: position of the multi-cycle op inside Execute (-1 = none), counters
  int m_pos   = -1;
  int m_stall = 0;
  int m_flush = 0;

`ifdef HAZARD_PERF_CNT_EN
  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
`else
  pipe_hazard_ctrl_if hz ();
`endif

  pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  always #5 clk = ~clk;

  // vector order: ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, EnE, BubbleM, BusyE
  function automatic logic [10:0] obs_vec();
    return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE,
            hz.EnE, hz.BubbleM, hz.BusyE};
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (hz.RegWriteM && hz.RdM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int cur_pos();
    return (m_pos < 0 && hz.MultiCycleE) ? 0 : m_pos;
  endfunction

  function automatic logic [10:0] model_out();
    int   cur;
    logic mc, lw, st;
    if (reset) return RST_VEC;
    cur = cur_pos();
    mc  = (cur >= 0) && (cur < MC_LAT - 1);
    lw  = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
          (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    st  = lw | mc;
    return {fwd(hz.Rs1E), fwd(hz.Rs2E), st, st, hz.PCSrcE & ~mc,
            (lw | hz.PCSrcE) & ~mc, ~mc, mc, cur >= 1};
  endfunction

  // Advance one clock: model steps at the edge, inputs may change 1 time unit later.
  task automatic tick();
    int          cur;
    logic [10:0] e;
    @(posedge clk);
    if (reset) begin
      m_pos = -1; m_stall = 0; m_flush = 0;
    end else begin
      e   = model_out();
      cur = cur_pos();
      if (cur >= 0) m_pos = (cur + 1 >= MC_LAT) ? -1 : cur + 1;
      if (e[5] && m_stall < CMAX) m_stall++;
      if ((e[4] || e[3]) && m_flush < CMAX) m_flush++;
    end
    #1;
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) begin m_pos = -1; m_stall = 0; m_flush = 0; end
  endtask

  task automatic set_idle();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
    hz.ResultSrcE = '0; hz.PCSrcE = 0; hz.MultiCycleE = 0;
    hz.RdM = '0; hz.RdW = '0; hz.RegWriteM = 0; hz.RegWriteW = 0;
  endtask

  task automatic randomize_inputs(input bit allow_mc);
    hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
    hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
    hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
    hz.RdW  = 5'($urandom_range(0, 3));
    hz.ResultSrcE = 2'($urandom_range(0, 3));
    hz.PCSrcE     = ($urandom_range(0, 3) == 0);
    hz.RegWriteM  = 1'($urandom); hz.RegWriteW = 1'($urandom);
    hz.MultiCycleE = allow_mc && ($urandom_range(0, 5) == 0);
  endtask

  task automatic test_reset();
    logic [10:0] o;
    set_reset(1'b1);
    randomize_inputs(1'b1);
    hz.MultiCycleE = 1; hz.PCSrcE = 1;
    @(negedge clk);
    o = obs_vec(); n_chk++;
    if (o !== RST_VEC) $display("FAIL reset_outputs got=%b want=%b", o, RST_VEC);
    else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
    n_chk++;
    if (hz.StallCnt !== 2'd0 || hz.FlushCnt !== 2'd0)
      $display("FAIL reset_counters got=%0d/%0d want=0/0", hz.StallCnt, hz.FlushCnt);
    else n_pass++;
`endif
    set_idle();
    set_reset(1'b0);
    tick();
  endtask

  task automatic test_forwarding();
    logic [1:0]  want [3] = '{2'b10, 2'b01, 2'b00};
    logic [10:0] o, e;
    set_idle();
    hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1; hz.Rs1E = 5; hz.Rs2E = 9;
    for (int s = 0; s < 3; s++) begin
      if (s == 1) hz.RegWriteM = 0;
      if (s == 2) begin hz.Rs1E = 0; hz.RdM = 0; end
      @(negedge clk);
      n_chk++;
      if (hz.ForwardAE !== want[s])
        $display("FAIL fwd_step%0d ForwardAE got=%b want=%b", s, hz.ForwardAE, want[s]);
      else n_pass++;
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      randomize_inputs(1'b0);
      @(negedge clk);
      o = obs_vec(); e = model_out(); n_chk++;
      if (o !== e) $display("FAIL fwd_random%0d got=%b want=%b", i, o, e);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [3:0] o;
    set_idle();
    hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7; hz.Rs1D = 3;
    @(negedge clk);
    o = {hz.StallF, hz.StallD, hz.FlushE, hz.EnE}; n_chk++;
    if (o !== 4'b1111) $display("FAIL load_use got=%b want=1111", o);
    else n_pass++;
    hz.RdE = 0; hz.Rs2D = 0;
    #1;
    o = {hz.StallF, hz.StallD, hz.FlushE, hz.EnE}; n_chk++;
    if (o !== 4'b0001) $display("FAIL load_use_x0 got=%b want=0001", o);
    else n_pass++;
    tick();
  endtask

  task automatic test_branch();
    logic [3:0] o;
    set_idle();
    hz.PCSrcE = 1; hz.ResultSrcE = 2'b01; hz.RdE = 4; hz.Rs1D = 6; hz.Rs2D = 2;
    @(negedge clk);
    o = {hz.FlushD, hz.FlushE, hz.StallF, hz.StallD}; n_chk++;
    if (o !== 4'b1100) $display("FAIL branch_flush got=%b want=1100", o);
    else n_pass++;
    tick();
    set_idle();
  endtask

  task automatic test_multicycle();
    logic [4:0] o, w;
    set_idle();
    for (int c = 0; c <= MC_LAT; c++) begin
      hz.MultiCycleE = (c < MC_LAT);
      hz.PCSrcE      = (c < MC_LAT);
      @(negedge clk);
      // StallD, EnE, BubbleM, FlushE, BusyE
      w = {c < MC_LAT - 1, c >= MC_LAT - 1, c < MC_LAT - 1, c == MC_LAT - 1,
           c >= 1 && c < MC_LAT};
      o = {hz.StallD, hz.EnE, hz.BubbleM, hz.FlushE, hz.BusyE}; n_chk++;
      if (o !== w) $display("FAIL multicycle_c%0d got=%b want=%b", c, o, w);
      else n_pass++;
      tick();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_busy();
    logic [10:0] o;
    int          stalls;
    set_idle();
    hz.MultiCycleE = 1;
    tick();
    hz.MultiCycleE = 0;
    tick();
    hz.MultiCycleE = 1;
    set_reset(1'b1);
    #1;
    o = obs_vec(); n_chk++;
    if (o !== RST_VEC) $display("FAIL reset_mid_busy got=%b want=%b", o, RST_VEC);
    else n_pass++;
    @(negedge clk);
    hz.MultiCycleE = 0;
    set_reset(1'b0);
    tick();
    stalls = 0;
    hz.MultiCycleE = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (hz.StallD === 1'b1) stalls++;
      tick();
      hz.MultiCycleE = 0;
    end
    n_chk++;
    if (stalls != MC_LAT - 1)
      $display("FAIL restart_stall_cycles got=%0d want=%0d", stalls, MC_LAT - 1);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [10:0] o, e;
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(1'b1);
      set_reset($urandom_range(0, 49) == 0);
      @(negedge clk);
      o = obs_vec(); e = model_out(); n_chk++;
      if (o !== e) $display("FAIL random%0d got=%b want=%b", i, o, e);
      else n_pass++;
      tick();
`ifdef HAZARD_PERF_CNT_EN
      n_chk++;
      if (int'(hz.StallCnt) != m_stall || int'(hz.FlushCnt) != m_flush)
        $display("FAIL random_cnt%0d got=%0d/%0d want=%0d/%0d", i, hz.StallCnt, hz.FlushCnt,
                 m_stall, m_flush);
      else n_pass++;
`endif
    end
    set_reset(1'b0);
    set_idle();
    tick();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    set_idle();
    set_reset(1'b1);
    tick();
    set_reset(1'b0);
    for (int c = 0; c < MC_LAT; c++) begin
      hz.MultiCycleE = 1;
      hz.PCSrcE      = (c < MC_LAT - 1);
      tick();
    end
    set_idle();
    n_chk++;
    if (hz.StallCnt !== 2'd3 || hz.FlushCnt !== 2'd0)
      $display("FAIL perf_mc got=%0d/%0d want=3/0", hz.StallCnt, hz.FlushCnt);
    else n_pass++;
    hz.PCSrcE = 1;
    tick();
    hz.PCSrcE = 0;
    n_chk++;
    if (hz.FlushCnt !== 2'd1) $display("FAIL perf_flush got=%0d want=1", hz.FlushCnt);
    else n_pass++;
    set_reset(1'b1);
    tick();
    set_reset(1'b0);
    hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7;
    repeat (5) tick();
    set_idle();
    n_chk++;
    if (hz.StallCnt !== 2'd3) $display("FAIL perf_sat got=%0d want=3", hz.StallCnt);
    else n_pass++;
  endtask
`endif

  initial begin
    set_idle();
    set_reset(1'b1);
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_multicycle();
    test_reset_mid_busy();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the five-stage RISC-V pipeline. It drives the enable and flush controls consumed by the Decode→Execute pipeline register. It also drives the forwarding selects for the Execute-stage ALU operands. It sequences multi-cycle Execute operations (mul/div) with a countdown FSM that holds the Execute register and injects bubbles into Memory.

## Interface
Parameters:
- MC_LAT, 4, total cycles a multi-cycle op occupies Execute; legal range 2..255
- CNT_W, 32, width of performance counters (used only with macro)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- Rs1D, Rs2D  in  5  Decode source registers
- Rs1E, Rs2E, RdE  in  5  Execute source and destination registers
- ResultSrcE  in  2  Execute result source; 2'b01 = load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- MultiCycleE  in  1  Execute op is multi-cycle
- RdM, RdW  in  5  Memory/Writeback destination registers
- RegWriteM, RegWriteW  in  1  Memory/Writeback register write enables
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 Writeback result, 10 Memory ALU result
- StallF, StallD  out  1  hold the PC and Fetch→Decode registers
- FlushD  out  1  clear the Fetch→Decode register
- FlushE  out  1  clear the Decode→Execute register (synchronous bubble)
- EnE  out  1  enable of the Decode→Execute register
- BubbleM  out  1  insert a bubble into the Execute→Memory register
- BusyE  out  1  FSM in BUSY
- StallCnt, FlushCnt  out  CNT_W  performance counters (macro only)

## Operation
- Forwarding, for ForwardAE (ForwardBE is the same using Rs2E):
  - 10 if RegWriteM & RdM==Rs1E & Rs1E!=0
  - else 01 if RegWriteW & RdW==Rs1E & Rs1E!=0
  - else 00
  - Memory takes priority over Writeback. x0 is never forwarded.
- Load-use: lwStall = (ResultSrcE==2'b01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Multi-cycle FSM, two states, with down-counter cnt (8 bits):
  - IDLE:
    - if MultiCycleE: mcStall=1, load cnt=MC_LAT-2, go to BUSY
    - else mcStall=0
  - BUSY:
    - if cnt!=0: mcStall=1, cnt decrements
    - if cnt==0: mcStall=0 (release cycle), go to IDLE
- Output equations:
  - StallF = StallD = lwStall | mcStall
  - EnE = ~mcStall
  - BubbleM = mcStall
  - FlushE = (lwStall | PCSrcE) & ~mcStall
  - FlushD = PCSrcE & ~mcStall
  - BusyE = state==BUSY
- Simultaneous events: mcStall has priority over load-use and branch flush. The Execute register holds, so its flush is suppressed.
- MultiCycleE sampled in the BUSY release cycle does not retrigger the FSM. The next op is evaluated only after it is in IDLE.

## Timing
- Forwarding and load-use/branch controls are combinational from the inputs, with zero latency.
- A multi-cycle op arriving in Execute at cycle 0:
  - StallF/StallD/BubbleM=1 and EnE=0 during cycles 0..MC_LAT-2
  - release at cycle MC_LAT-1: EnE=1
  - the op leaves Execute at the edge ending cycle MC_LAT-1
  - total stall cycles = MC_LAT-1
- While reset is asserted:
  - state=IDLE, cnt=0, counters=0
  - outputs forced: StallF=StallD=FlushD=FlushE=BubbleM=BusyE=0, EnE=1, ForwardAE=ForwardBE=00
- Reset mid-BUSY aborts the sequence immediately (asynchronous). After deassertion the FSM is in IDLE.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCnt increments on every cycle with StallD=1
  - FlushCnt increments on every cycle with FlushE=1 or FlushD=1
  - both saturate at all-ones; reset to 0
- Undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- RdM=5/RegWriteM=1 and RdW=5/RegWriteW=1, Rs1E=5 -> ForwardAE=10. Then RegWriteM=0 -> 01. Then Rs1E=0, RdM=0 -> 00.
- ResultSrcE=01, RdE=7, Rs2D=7, one cycle -> StallF=StallD=FlushE=1, EnE=1. Same with RdE=0 -> all 0.
- PCSrcE=1 with lwStall=0 -> FlushD=FlushE=1, StallF=StallD=0.
- MC_LAT=4, MultiCycleE held 4 cycles:
  - cycles 0-2: StallD=1, EnE=0, BubbleM=1, FlushE=0 even with PCSrcE=1
  - BusyE=1 in cycles 1-3
  - cycle 3: EnE=1, StallD=0
  - cycle 4: IDLE
- Reset asserted in BUSY with cnt=1 -> outputs immediately at reset values. After release, a new MultiCycleE starts a full 3-cycle stall.
- With HAZARD_PERF_CNT_EN, CNT_W=2: 5 consecutive load-use cycles -> StallCnt=3 (saturated). FlushCnt unchanged until PCSrcE pulses.
